// File: rtl/proc_sequencer.sv
// proc_sequencer: instruction store and issue sequencer for simple8BitProcessor, capturing
// dataOut after each store. Define PROC_SEQ_LOOP_EN to let loop_mode repeat the program.
module proc_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [16:0]   prog_data,
    input  logic          start,
    input  logic [AW-1:0] last_addr,
    input  logic          abort,
    input  logic          loop_mode,
    output logic [8:0]    proc_func,
    output logic [7:0]    proc_data,
    input  logic [7:0]    proc_dout,
    output logic          busy,
    output logic          done,
    output logic [7:0]    result,
    output logic          result_valid
);

    localparam int unsigned FW = 9;
    localparam int unsigned DW = 8;
    localparam int unsigned EW = FW + DW;

    localparam logic [2:0]    OP_STORE = 3'b111;
    localparam logic [FW-1:0] NOP_FUNC = 9'b001_000_000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] last_q, last_d;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] fetch_c;

    logic [FW-1:0] func_d;
    logic [DW-1:0] data_d;
    logic          busy_d;
    logic          done_d;
    logic          store_d;
    logic [1:0]    store_pipe_q;
    logic          wrap_c;

`ifdef PROC_SEQ_LOOP_EN
    assign wrap_c = loop_mode;
`else
    logic unused_loop_mode;
    assign unused_loop_mode = loop_mode;
    assign wrap_c           = 1'b0;
`endif

    // Program store: writable only while idle, never reset.
    always_ff @(posedge clock) begin
        if (prog_we && (state_q == S_IDLE)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Entry about to be issued; a same-cycle write in IDLE is forwarded so start sees it.
    always_comb begin
        fetch_c = mem[pc_d];
        if ((state_q == S_IDLE) && prog_we && (prog_addr == pc_d)) begin
            fetch_c = prog_data;
        end
    end

    // State, PC and last-address registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic; pc always names the entry currently presented.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    last_d  = last_addr;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                end else if (pc_q == last_q) begin
                    pc_d = '0;
                    if (!wrap_c) begin
                        state_d = S_DONE;
                    end
                end else begin
                    pc_d = pc_q + AW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        func_d  = NOP_FUNC;
        data_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        store_d = 1'b0;
        if (state_d == S_RUN) begin
            func_d  = fetch_c[FW-1:0];
            data_d  = fetch_c[EW-1:FW];
            busy_d  = 1'b1;
            store_d = (fetch_c[FW-1:FW-3] == OP_STORE);
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            proc_func <= NOP_FUNC;
            proc_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            proc_func <= func_d;
            proc_data <= data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Store capture: presented, executed next edge, dataOut sampled the edge after.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            store_pipe_q <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            store_pipe_q <= {store_pipe_q[0], store_d};
            result_valid <= store_pipe_q[1];
            if (store_pipe_q[1]) begin
                result <= proc_dout;
            end
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a small behavioural model of the processor
// (load-imm, mov, add, store) driving proc_dout.
module tb_proc_sequencer;

    localparam logic [8:0] NOP = 9'b001_000_000;

    logic       clock;
    logic       reset;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [16:0] prog_data;
    logic       start;
    logic [3:0] last_addr;
    logic       abort;
    logic       loop_mode;
    logic [8:0] proc_func;
    logic [7:0] proc_data;
    logic [7:0] proc_dout;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       result_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int rv_cnt   = 0;

    logic [16:0] prog_a [5];
    logic [16:0] prog_l [3];
    logic [7:0]  regs [8];
    logic [7:0]  dout;

    proc_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .start        (start),
        .last_addr    (last_addr),
        .abort        (abort),
        .loop_mode    (loop_mode),
        .proc_func    (proc_func),
        .proc_data    (proc_data),
        .proc_dout    (proc_dout),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Processor model: executes the presented word on the next rising edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            dout <= 8'h00;
        end else begin
            case (proc_func[8:6])
                3'b000: regs[proc_func[5:3]] <= proc_data;
                3'b001: regs[proc_func[5:3]] <= regs[proc_func[2:0]];
                3'b010: regs[proc_func[5:3]] <= regs[proc_func[5:3]] + regs[proc_func[2:0]];
                3'b111: dout <= regs[proc_func[5:3]];
                default: ;
            endcase
        end
    end
    assign proc_dout = dout;

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (result_valid) rv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [16:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    // Runs program A (last_addr=4); optionally pokes a write and a restart mid-run.
    task automatic run_a(input bit disturb);
        int d0;
        int r0;
        d0 = done_cnt;
        r0 = rv_cnt;
        start     = 1'b1;
        last_addr = 4'd4;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("runA_func%0d", k), 32'(proc_func), 32'(prog_a[k][8:0]));
            check($sformatf("runA_data%0d", k), 32'(proc_data), 32'(prog_a[k][16:9]));
            check($sformatf("runA_busy%0d", k), 32'(busy), 32'd1);
            if (disturb && k == 1) begin
                prog_we   = 1'b1;
                prog_addr = 4'd2;
                prog_data = {8'hEE, 9'b111_111_111};
            end
            if (disturb && k == 2) start = 1'b1;
            step();
            prog_we = 1'b0;
            start   = 1'b0;
        end
        check("runA_done", 32'(done), 32'd1);
        check("runA_busy_end", 32'(busy), 32'd0);
        check("runA_nop_end", 32'(proc_func), 32'(NOP));
        check("runA_rv_early", 32'(result_valid), 32'd0);
        step();
        check("runA_rv", 32'(result_valid), 32'd1);
        check("runA_result", 32'(result), 32'd9);
        check("runA_done_low", 32'(done), 32'd0);
        step();
        check("runA_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("runA_rv_cnt", 32'(rv_cnt - r0), 32'd1);
        check("runA_idle_func", 32'(proc_func), 32'(NOP));
    endtask

    initial begin
        int d0;
        reset     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        last_addr = '0;
        abort     = 1'b0;
        loop_mode = 1'b0;

        prog_a[0] = {8'd4, 9'b000_001_000};
        prog_a[1] = {8'd5, 9'b000_000_000};
        prog_a[2] = {8'd0, 9'b010_001_000};
        prog_a[3] = {8'd0, 9'b001_011_001};
        prog_a[4] = {8'd0, 9'b111_011_000};
        prog_l[0] = {8'd1, 9'b000_101_000};
        prog_l[1] = {8'd0, 9'b010_101_101};
        prog_l[2] = {8'd0, 9'b001_110_101};

        #2;
        check("rst_func", 32'(proc_func), 32'(NOP));
        check("rst_busy", 32'(busy), 32'd0);
        step();
        step();
        reset = 1'b0;

        // Idle after reset: NOP and zeros for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_func", 32'(proc_func), 32'(NOP));
            check("idle_data", 32'(proc_data), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_result", 32'(result), 32'd0);
        end

        for (int k = 0; k < 5; k++) load(4'(k), prog_a[k]);
        run_a(1'b0);
        run_a(1'b1);
        run_a(1'b0);

        // Abort while entry 2 is presented; store at entry 1 still captures.
        load(4'd0, {8'h2A, 9'b000_010_000});
        load(4'd1, {8'h00, 9'b111_010_000});
        load(4'd2, {8'h00, 9'b001_100_001});
        d0 = done_cnt;
        start     = 1'b1;
        last_addr = 4'd4;
        step();
        start = 1'b0;
        check("abort_e0", 32'(proc_func), 32'(9'b000_010_000));
        step();
        check("abort_e1", 32'(proc_func), 32'(9'b111_010_000));
        step();
        check("abort_e2", 32'(proc_func), 32'(9'b001_100_001));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_nop", 32'(proc_func), 32'(NOP));
        check("abort_data", 32'(proc_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rv", 32'(result_valid), 32'd1);
        check("abort_result", 32'(result), 32'h2A);
        step();
        check("abort_nop2", 32'(proc_func), 32'(NOP));
        step();
        step();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // last_addr=0, entry 0 written in the same cycle as start.
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = {8'h00, 9'b111_001_000};
        start     = 1'b1;
        last_addr = 4'd0;
        step();
        prog_we = 1'b0;
        start   = 1'b0;
        check("one_func", 32'(proc_func), 32'(9'b111_001_000));
        check("one_busy", 32'(busy), 32'd1);
        step();
        check("one_done", 32'(done), 32'd1);
        check("one_busy_end", 32'(busy), 32'd0);
        check("one_nop", 32'(proc_func), 32'(NOP));
        check("one_rv_early", 32'(result_valid), 32'd0);
        step();
        check("one_rv", 32'(result_valid), 32'd1);
        check("one_result", 32'(result), 32'd9);
        check("one_done_low", 32'(done), 32'd0);
        step();

        // Three-entry program with loop_mode requested.
        for (int k = 0; k < 3; k++) load(4'(k), prog_l[k]);
        loop_mode = 1'b1;
        start     = 1'b1;
        last_addr = 4'd2;
        step();
        start = 1'b0;
`ifdef PROC_SEQ_LOOP_EN
        for (int i = 0; i < 6; i++) begin
            check($sformatf("loop_func%0d", i), 32'(proc_func), 32'(prog_l[i % 3][8:0]));
            check($sformatf("loop_busy%0d", i), 32'(busy), 32'd1);
            if (i == 4) loop_mode = 1'b0;
            step();
        end
`else
        for (int i = 0; i < 3; i++) begin
            check($sformatf("loop_func%0d", i), 32'(proc_func), 32'(prog_l[i][8:0]));
            check($sformatf("loop_busy%0d", i), 32'(busy), 32'd1);
            step();
        end
`endif
        loop_mode = 1'b0;
        check("loop_done", 32'(done), 32'd1);
        check("loop_nop", 32'(proc_func), 32'(NOP));
        check("loop_busy_end", 32'(busy), 32'd0);
        step();
        step();

        // Asynchronous reset in the middle of a run.
        for (int k = 0; k < 5; k++) load(4'(k), prog_a[k]);
        start     = 1'b1;
        last_addr = 4'd4;
        step();
        start = 1'b0;
        step();
        check("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_func", 32'(proc_func), 32'(NOP));
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_rv", 32'(result_valid), 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        check("mid_after_busy", 32'(busy), 32'd0);
        check("mid_after_func", 32'(proc_func), 32'(NOP));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
